// File: rtl/dso100fb_pkg.sv
// Shared encodings for the DSO100 framebuffer fetch path.
// The ERROR state exists only when DSO100FB_FETCH_HRESP_EN is defined.
package dso100fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_BURST = 3'd2,
    ST_DRAIN = 3'd3
`ifdef DSO100FB_FETCH_HRESP_EN
    , ST_ERROR = 3'd4
`endif
  } fetch_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  function automatic logic [2:0] hburst_code(input int burst_len);
    case (burst_len)
      4:       return HBURST_INCR4;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR8;
    endcase
  endfunction

endpackage

// File: rtl/dso100fb_fetch2d_agen.sv
// 2D burst address generator: burst/line/frame down-counters and frame-done timing.
// Shadows reload from the live inputs on start and at every frame wrap.
module dso100fb_fetch2d_agen #(
  parameter int BURST_BYTES = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] base,
  input  logic [31:0] stride,
  input  logic [15:0] line_bursts,
  input  logic [15:0] lines,
  output logic [31:0] burst_ptr,
  output logic        frame_done
);

  localparam logic [31:0] ALIGN_MASK = ~(32'(BURST_BYTES) - 32'd1);

  logic [31:0] stride_sh;
  logic [31:0] line_ptr;
  logic [15:0] lbursts_m1_sh;
  logic [15:0] burst_cnt;
  logic [15:0] line_cnt;
  logic        burst_tc;
  logic        line_tc;
  logic        restart;

  // A programmed count of zero behaves as one.
  function automatic logic [15:0] minus1(input logic [15:0] n);
    return (n == 16'd0) ? 16'd0 : n - 16'd1;
  endfunction

  assign burst_tc   = (burst_cnt == 16'd0);
  assign line_tc    = (line_cnt == 16'd0);
  assign frame_done = advance && burst_tc && line_tc;
  assign restart    = load || frame_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stride_sh     <= '0;
      lbursts_m1_sh <= '0;
      line_ptr      <= '0;
      burst_ptr     <= '0;
      burst_cnt     <= '0;
      line_cnt      <= '0;
    end else if (restart) begin
      stride_sh     <= stride & ALIGN_MASK;
      lbursts_m1_sh <= minus1(line_bursts);
      line_ptr      <= base & ALIGN_MASK;
      burst_ptr     <= base & ALIGN_MASK;
      burst_cnt     <= minus1(line_bursts);
      line_cnt      <= minus1(lines);
    end else if (advance) begin
      if (!burst_tc) begin
        burst_cnt <= burst_cnt - 16'd1;
        burst_ptr <= burst_ptr + 32'(BURST_BYTES);
      end else begin
        line_cnt  <= line_cnt - 16'd1;
        burst_cnt <= lbursts_m1_sh;
        line_ptr  <= line_ptr + stride_sh;
        burst_ptr <= line_ptr + stride_sh;
      end
    end
  end

endmodule

// File: rtl/dso100fb_fetch2d.sv
// AHB-Lite burst read master fetching a 2D framebuffer region into a FIFO.
// Define DSO100FB_FETCH_HRESP_EN to abort on HRESP errors and enable the ERROR state.
//
// state | meaning
// IDLE  | stopped; FETCH_EN=1 latches config and starts a frame
// WAIT  | between bursts; waiting for FIFO space
// BURST | issuing BURST_LEN address phases
// DRAIN | last data phase outstanding, HTRANS=IDLE
// ERROR | bus error seen; held until FETCH_EN=0
module dso100fb_fetch2d
  import dso100fb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FETCH_EN,
  input  logic [31:0]       FETCH_FB_BASE,
  input  logic [31:0]       FETCH_STRIDE,
  input  logic [15:0]       FETCH_LINE_BURSTS,
  input  logic [15:0]       FETCH_LINES,
  output logic [31:0]       HADDR,
  output logic [2:0]        HBURST,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic [3:0]        HPROT,
  output logic              HWRITE,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic              FIFO_SPACE_OK,
  output logic              FIFO_WRITE,
  output logic [DATA_W-1:0] FIFO_DATA,
  output logic              FETCH_FRAME_DONE,
  output logic              FETCH_ERR
);

  localparam int BYTES       = DATA_W / 8;
  localparam int BYTE_SH     = $clog2(BYTES);
  localparam int BURST_BYTES = BURST_LEN * BYTES;
  localparam int BW          = $clog2(BURST_LEN);

  fetch_state_t state, state_nx;
  logic [BW-1:0] beat_idx;
  logic [31:0]   burst_ptr;
  logic          data_pend;
  logic          addr_acc;
  logic          data_done;
  logic          last_beat;
  logic          load;
  logic          advance;
  logic          abort;

  assign HBURST    = hburst_code(BURST_LEN);
  assign HSIZE     = 3'(BYTE_SH);
  assign HPROT     = 4'b0011;
  assign HWRITE    = 1'b0;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = '0;
  assign FIFO_DATA = HRDATA;

  assign addr_acc  = (state == ST_BURST) && HREADY;
  assign data_done = data_pend && HREADY;
  assign last_beat = (beat_idx == BW'(BURST_LEN - 1));
  assign advance   = (state == ST_DRAIN) && data_done;

  assign HADDR      = burst_ptr + (32'(beat_idx) << BYTE_SH);
  assign HTRANS     = (state != ST_BURST) ? HTRANS_IDLE :
                      (beat_idx == '0)    ? HTRANS_NONSEQ : HTRANS_SEQ;
  assign FIFO_WRITE = data_done;

`ifdef DSO100FB_FETCH_HRESP_EN
  logic fetch_err;

  // First cycle of the two-cycle error response; the errored beat is never pushed.
  assign abort     = data_pend && HRESP && !HREADY;
  assign FETCH_ERR = fetch_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                               fetch_err <= 1'b0;
    else if (abort)                           fetch_err <= 1'b1;
    else if (state == ST_ERROR && !FETCH_EN)  fetch_err <= 1'b0;
  end
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign abort        = 1'b0;
  assign FETCH_ERR    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (FETCH_EN) begin
          load     = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!FETCH_EN)          state_nx = ST_IDLE;
        else if (FIFO_SPACE_OK) state_nx = ST_BURST;
      end
      ST_BURST: begin
        if (addr_acc && last_beat) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (data_done) state_nx = FETCH_EN ? ST_WAIT : ST_IDLE;
      end
`ifdef DSO100FB_FETCH_HRESP_EN
      ST_ERROR: begin
        if (!FETCH_EN) state_nx = ST_IDLE;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
`ifdef DSO100FB_FETCH_HRESP_EN
    if (abort) state_nx = ST_ERROR;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      beat_idx  <= '0;
      data_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (abort) begin
        beat_idx  <= '0;
        data_pend <= 1'b0;
      end else begin
        if (addr_acc) beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
        if (addr_acc)       data_pend <= 1'b1;
        else if (data_done) data_pend <= 1'b0;
      end
    end
  end

  dso100fb_fetch2d_agen #(
    .BURST_BYTES(BURST_BYTES)
  ) u_agen (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load       (load),
    .advance    (advance),
    .base       (FETCH_FB_BASE),
    .stride     (FETCH_STRIDE),
    .line_bursts(FETCH_LINE_BURSTS),
    .lines      (FETCH_LINES),
    .burst_ptr  (burst_ptr),
    .frame_done (FETCH_FRAME_DONE)
  );

endmodule

// File: tb/tb_dso100fb_fetch2d.sv
// Scoreboard bench for dso100fb_fetch2d (DATA_W=32, BURST_LEN=8); the slave returns each beat's address as data.
// Build with DSO100FB_FETCH_HRESP_EN defined to exercise the error-abort path.
module tb_dso100fb_fetch2d;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FETCH_EN = 1'b0;
  logic [31:0] FETCH_FB_BASE = 32'h1000;
  logic [31:0] FETCH_STRIDE = 32'h400;
  logic [15:0] FETCH_LINE_BURSTS = 16'd2;
  logic [15:0] FETCH_LINES = 16'd2;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        FIFO_SPACE_OK = 1'b1;
  logic        FIFO_WRITE;
  logic [31:0] FIFO_DATA;
  logic        FETCH_FRAME_DONE;
  logic        FETCH_ERR;

  int checks = 0;
  int failures = 0;
  int push_cnt = 0;
  int nonseq_cnt = 0;
  int active_cnt = 0;

  logic [31:0] exp_data[$];
  logic        exp_fd[$];
  logic [31:0] exp_addr[$];
  logic [31:0] ed;
  logic        ef;
  logic [31:0] ea;
  logic [31:0] dph_addr = 32'h0;

  dso100fb_fetch2d dut (
    .CLK(CLK), .RST_N(RST_N), .FETCH_EN(FETCH_EN),
    .FETCH_FB_BASE(FETCH_FB_BASE), .FETCH_STRIDE(FETCH_STRIDE),
    .FETCH_LINE_BURSTS(FETCH_LINE_BURSTS), .FETCH_LINES(FETCH_LINES),
    .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HPROT(HPROT), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .FIFO_SPACE_OK(FIFO_SPACE_OK), .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA(FIFO_DATA),
    .FETCH_FRAME_DONE(FETCH_FRAME_DONE), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  // Slave model: data phase returns the address accepted in the previous address phase.
  always @(posedge CLK) if (HREADY && HTRANS[1]) dph_addr <= HADDR;
  assign HRDATA = dph_addr;

  // Monitor: pops expected pushes and NONSEQ addresses as the DUT presents them.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (HTRANS != 2'b00) active_cnt++;
      if (FIFO_WRITE) begin
        push_cnt++;
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL push_unexpected data=%h", FIFO_DATA);
        end else begin
          ed = exp_data.pop_front();
          ef = exp_fd.pop_front();
          if (FIFO_DATA !== ed) begin
            failures++;
            $display("FAIL push_data got=%h exp=%h", FIFO_DATA, ed);
          end
          checks++;
          if (FETCH_FRAME_DONE !== ef) begin
            failures++;
            $display("FAIL frame_done at push %h got=%b exp=%b", ed, FETCH_FRAME_DONE, ef);
          end
        end
      end else if (FETCH_FRAME_DONE) begin
        checks++;
        failures++;
        $display("FAIL frame_done_without_push got=1 exp=0");
      end
      if (HTRANS == 2'b10 && HREADY) begin
        nonseq_cnt++;
        checks++;
        if (exp_addr.size() == 0) begin
          failures++;
          $display("FAIL nonseq_unexpected addr=%h", HADDR);
        end else begin
          ea = exp_addr.pop_front();
          if (HADDR !== ea) begin
            failures++;
            $display("FAIL nonseq_addr got=%h exp=%h", HADDR, ea);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_burst(input logic [31:0] a, input logic last);
    for (int k = 0; k < 8; k++) begin
      exp_data.push_back(a + 32'(4 * k));
      exp_fd.push_back(last && (k == 7));
    end
  endtask

  task automatic wait_addr(input logic [31:0] a, input logic [1:0] t);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1);
      if (HADDR == a && HTRANS == t) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_addr timeout got=%h exp=%h", HADDR, a);
    end
  endtask

  task automatic wait_nonseq(input int n);
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc(1);
      if (nonseq_cnt >= n) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_nonseq timeout got=%0d exp=%0d", nonseq_cnt, n);
    end
  endtask

  task automatic wait_drain();
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc(1);
      if (exp_data.size() == 0 && exp_addr.size() == 0 && HTRANS == 2'b00) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_drain timeout pushes_left=%0d addrs_left=%0d", exp_data.size(), exp_addr.size());
    end
    cyc(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int p0, n0, a0;
    cyc(3);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_fifo_write", 32'(FIFO_WRITE), 32'h0);
    chk("rst_frame_done", 32'(FETCH_FRAME_DONE), 32'h0);
    chk("rst_fetch_err", 32'(FETCH_ERR), 32'h0);
    chk("hburst_incr8", 32'(HBURST), 32'h5);
    chk("hsize_word", 32'(HSIZE), 32'h2);
    RST_N = 1'b1;
    cyc(2);

    // Full 2x2 frame then the wrap burst.
    p0 = push_cnt; n0 = nonseq_cnt;
    exp_addr.push_back(32'h1000); exp_addr.push_back(32'h1020);
    exp_addr.push_back(32'h1400); exp_addr.push_back(32'h1420);
    exp_addr.push_back(32'h1000);
    push_burst(32'h1000, 1'b0); push_burst(32'h1020, 1'b0);
    push_burst(32'h1400, 1'b0); push_burst(32'h1420, 1'b1);
    push_burst(32'h1000, 1'b0);
    FETCH_EN = 1'b1;
    wait_nonseq(n0 + 5);
    FETCH_EN = 1'b0;
    wait_drain();
    chk("frame_pushes", 32'(push_cnt - p0), 32'd40);

    // FIFO back-pressure between bursts.
    p0 = push_cnt; n0 = nonseq_cnt;
    exp_addr.push_back(32'h1000);
    push_burst(32'h1000, 1'b0);
    FETCH_EN = 1'b1;
    wait_nonseq(n0 + 1);
    FIFO_SPACE_OK = 1'b0;
    wait_drain();
    a0 = active_cnt; p0 = push_cnt;
    cyc(20);
    chk("space_htrans_idle", 32'(active_cnt - a0), 32'd0);
    chk("space_no_push", 32'(push_cnt - p0), 32'd0);
    exp_addr.push_back(32'h1020);
    push_burst(32'h1020, 1'b0);
    FIFO_SPACE_OK = 1'b1;
    wait_nonseq(n0 + 2);
    FETCH_EN = 1'b0;
    wait_drain();
    chk("space_resume_pushes", 32'(push_cnt - p0), 32'd8);

    // Wait states on beat 4.
    p0 = push_cnt;
    exp_addr.push_back(32'h1000);
    push_burst(32'h1000, 1'b0);
    FETCH_EN = 1'b1;
    wait_addr(32'h100C, 2'b11);
    FETCH_EN = 1'b0;
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall_haddr", HADDR, 32'h100C);
      chk("stall_htrans", 32'(HTRANS), 32'h3);
    end
    HREADY = 1'b1;
    wait_drain();
    chk("stall_pushes", 32'(push_cnt - p0), 32'd8);

    // FETCH_EN dropped on beat 2 completes the burst then idles.
    p0 = push_cnt;
    exp_addr.push_back(32'h1000);
    push_burst(32'h1000, 1'b0);
    FETCH_EN = 1'b1;
    wait_addr(32'h1004, 2'b11);
    FETCH_EN = 1'b0;
    wait_drain();
    chk("drop_pushes", 32'(push_cnt - p0), 32'd8);
    n0 = nonseq_cnt;
    cyc(10);
    chk("drop_no_nonseq", 32'(nonseq_cnt - n0), 32'd0);
    chk("drop_htrans_idle", 32'(HTRANS), 32'h0);

    // Base reprogrammed mid-frame takes effect after wrap.
    FETCH_LINE_BURSTS = 16'd1;
    n0 = nonseq_cnt;
    exp_addr.push_back(32'h1000); exp_addr.push_back(32'h1400); exp_addr.push_back(32'h8000);
    push_burst(32'h1000, 1'b0); push_burst(32'h1400, 1'b1); push_burst(32'h8000, 1'b0);
    FETCH_EN = 1'b1;
    wait_nonseq(n0 + 1);
    FETCH_FB_BASE = 32'h8000;
    wait_nonseq(n0 + 3);
    FETCH_EN = 1'b0;
    wait_drain();
    FETCH_FB_BASE = 32'h1000;
    FETCH_LINE_BURSTS = 16'd2;

    // Error response on beat 5.
    p0 = push_cnt;
    exp_addr.push_back(32'h1000);
`ifdef DSO100FB_FETCH_HRESP_EN
    for (int k = 0; k < 4; k++) begin
      exp_data.push_back(32'h1000 + 32'(4 * k));
      exp_fd.push_back(1'b0);
    end
    FETCH_EN = 1'b1;
    wait_addr(32'h1014, 2'b11);
    HREADY = 1'b0; HRESP = 1'b1;
    cyc(1);
    chk("err_htrans_idle", 32'(HTRANS), 32'h0);
    chk("err_flag_set", 32'(FETCH_ERR), 32'h1);
    HREADY = 1'b1;
    cyc(1);
    HRESP = 1'b0;
    cyc(10);
    chk("err_flag_sticky", 32'(FETCH_ERR), 32'h1);
    chk("err_htrans_held", 32'(HTRANS), 32'h0);
    chk("err_pushes", 32'(push_cnt - p0), 32'd4);
    FETCH_EN = 1'b0;
    cyc(2);
    chk("err_flag_cleared", 32'(FETCH_ERR), 32'h0);
    wait_drain();
`else
    push_burst(32'h1000, 1'b0);
    FETCH_EN = 1'b1;
    wait_addr(32'h1014, 2'b11);
    FETCH_EN = 1'b0;
    HREADY = 1'b0; HRESP = 1'b1;
    cyc(1);
    HREADY = 1'b1;
    cyc(1);
    HRESP = 1'b0;
    wait_drain();
    chk("noerr_pushes", 32'(push_cnt - p0), 32'd8);
    chk("noerr_flag", 32'(FETCH_ERR), 32'h0);
`endif

    // Reset mid-burst abandons it; restart begins at base.
    exp_addr.push_back(32'h1000);
    push_burst(32'h1000, 1'b0);
    FETCH_EN = 1'b1;
    wait_addr(32'h100C, 2'b11);
    RST_N = 1'b0;
    exp_data.delete(); exp_fd.delete(); exp_addr.delete();
    #1;
    chk("rstmid_fifo_write", 32'(FIFO_WRITE), 32'h0);
    chk("rstmid_htrans", 32'(HTRANS), 32'h0);
    cyc(2);
    chk("rstmid_haddr", HADDR, 32'h0);
    chk("rstmid_fifo_write_held", 32'(FIFO_WRITE), 32'h0);
    p0 = push_cnt; n0 = nonseq_cnt;
    exp_addr.push_back(32'h1000);
    push_burst(32'h1000, 1'b0);
    RST_N = 1'b1;
    wait_nonseq(n0 + 1);
    FETCH_EN = 1'b0;
    wait_drain();
    chk("rstmid_restart_pushes", 32'(push_cnt - p0), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dso100fb_fetch2d.md
DSO100FB_FETCH2D -- requirements
Module: dso100fb_fetch2d

Interface
REQ-001 SHALL have parameter DATA_W, default 32: AHB data and FIFO width, legal values 32 and 64.
REQ-002 SHALL have parameter BURST_LEN, default 8: beats per fixed burst, legal values 4, 8 and 16.
REQ-003 SHALL have port CLK  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port FETCH_EN  in  1  enable; high = fetch frames continuously.
REQ-006 SHALL have port FETCH_FB_BASE  in  32  frame start byte address; low log2(BURST_LEN*DATA_W/8) bits ignored.
REQ-007 SHALL have port FETCH_STRIDE  in  32  byte distance between line starts; same low bits ignored.
REQ-008 SHALL have port FETCH_LINE_BURSTS  in  16  bursts per line; 0 treated as 1.
REQ-009 SHALL have port FETCH_LINES  in  16  lines per frame; 0 treated as 1.
REQ-010 SHALL have port HADDR  out  32  AHB address.
REQ-011 SHALL have port HBURST  out  3  INCR4/INCR8/INCR16 (3'b011/101/111) per BURST_LEN.
REQ-012 SHALL have port HSIZE  out  3  log2(DATA_W/8).
REQ-013 SHALL have port HTRANS  out  2  IDLE/NONSEQ/SEQ.
REQ-014 SHALL have ports HPROT out 4 = 4'b0011, HWRITE out 1 = 0, HMASTLOCK out 1 = 0, HWDATA out DATA_W = 0, all constant.
REQ-015 SHALL have ports HRDATA in DATA_W, HREADY in 1 and HRESP in 1, the AHB-Lite read return.
REQ-016 SHALL have port FIFO_SPACE_OK  in  1  FIFO has at least BURST_LEN free entries.
REQ-017 SHALL have ports FIFO_WRITE out 1 (push strobe) and FIFO_DATA out DATA_W (= HRDATA).
REQ-018 SHALL have port FETCH_FRAME_DONE  out  1  one-cycle pulse on the last beat of each frame.
REQ-019 SHALL have port FETCH_ERR  out  1  sticky bus-error flag.

Function
REQ-020 SHALL implement states IDLE, WAIT, BURST, DRAIN and ERROR.
REQ-021 SHALL, in IDLE with FETCH_EN=1, latch BASE/STRIDE/LINE_BURSTS/LINES into shadows, set line and burst pointers to base, and enter WAIT.
REQ-022 SHALL move WAIT->BURST only when FIFO_SPACE_OK=1, and WAIT->IDLE when FETCH_EN=0.
REQ-023 SHALL in BURST issue exactly BURST_LEN beats: first NONSEQ, rest SEQ, HADDR incrementing by DATA_W/8, each beat held until HREADY=1; it never terminates a burst early for FIFO or FETCH_EN.
REQ-024 SHALL pipeline address and data phases, asserting FIFO_WRITE in the cycle a pending data phase completes with HREADY=1 (first push one cycle after the first accepted address phase).
REQ-025 SHALL after the last address phase enter DRAIN with HTRANS=IDLE, then on its data completion go to WAIT, or to IDLE if FETCH_EN=0.
REQ-026 SHALL advance the burst pointer per burst; after LINE_BURSTS bursts set line start += STRIDE (32-bit modulo); after LINES lines restart at base.
REQ-027 SHALL at frame end reload the shadows from the inputs, so reprogramming takes effect only at frame boundaries.
REQ-028 SHALL pulse FETCH_FRAME_DONE coincident with the FIFO_WRITE of the frame's final beat.
REQ-029 SHALL never cross a 1 KB boundary within a burst, guaranteed by alignment and by BURST_LEN*DATA_W/8 <= 128.

Reset
REQ-030 SHALL on RST_N=0 force state IDLE, HTRANS=IDLE, HADDR=0, FIFO_WRITE=0, FETCH_FRAME_DONE=0, FETCH_ERR=0 and zero all shadows and pointers.
REQ-031 SHALL, when reset asserts mid-burst, abandon the burst with no further FIFO_WRITE, and restart from IDLE at the reloaded base.

Configuration
REQ-032 SHALL, with DSO100FB_FETCH_HRESP_EN defined, on HRESP=1 with HREADY=0 drive HTRANS=IDLE in the next cycle, suppress FIFO_WRITE for the errored beat and the rest of the burst, set FETCH_ERR and enter ERROR, leaving ERROR only via FETCH_EN=0 (which clears FETCH_ERR and enters IDLE).
REQ-033 SHALL, without DSO100FB_FETCH_HRESP_EN, ignore HRESP, tie FETCH_ERR to 0 and omit the ERROR state.

Structure
REQ-034 SHALL take the state encoding, HTRANS and HBURST codes from the shared package dso100fb_pkg.
REQ-035 SHALL place the 2D address generator (burst/line/frame counters, FRAME_DONE timing) in sub-module dso100fb_fetch2d_agen.

Verification
REQ-036 SHALL cover: 32-bit data, BURST_LEN=8, base 0x1000, stride 0x400, 2 bursts/line, 2 lines, HREADY=1 -> NONSEQ addresses 0x1000, 0x1020, 0x1400, 0x1420, then 0x1000; 32 pushes; FRAME_DONE on push 32.
REQ-037 SHALL cover: FIFO_SPACE_OK=0 after the first burst -> HTRANS stays IDLE, no pushes; raising it -> next NONSEQ at 0x1020.
REQ-038 SHALL cover: HREADY low 3 cycles on beat 4 -> HADDR and HTRANS held; exactly 8 pushes in order.
REQ-039 SHALL cover: FETCH_EN dropped on beat 2 -> beats 3-8 still issued, DRAIN, IDLE; base changed to 0x8000 mid-frame -> used only after frame wrap.
REQ-040 SHALL cover: macro defined, HRESP on beat 5 -> 4 pushes only, FETCH_ERR=1 until FETCH_EN=0; macro undefined -> 8 pushes and FETCH_ERR=0.
